// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the mem_lsu load/store unit.
// Data and address widths come from the A_BITS / D_BITS / MEMSIZE macros.
`ifndef A_BITS
`define A_BITS 8
`endif
`ifndef D_BITS
`define D_BITS 16
`endif
`ifndef MEMSIZE
`define MEMSIZE 64
`endif

package mem_lsu_pkg;

    localparam int AW    = `A_BITS;
    localparam int DW    = `D_BITS;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          error;
    } rsp_t;

    // The counter holds the remaining read cycles after the first one.
    function automatic logic [CNT_W-1:0] lat_to_count(input int latency);
        return CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Request/response handshake between the execute stage (master) and mem_lsu (slave).
interface mem_lsu_if;
    import mem_lsu_pkg::*;

    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );

endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: one-at-a-time load/store sequencer for the data-memory port, all outputs registered.
// Optional build macro MEM_LSU_BOUNDS_CHECK_EN faults requests whose address is >= MEM_DEPTH.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int MEM_DEPTH    = `MEMSIZE
) (
    input  logic          clk,
    input  logic          rst,
    mem_lsu_if.slave      bus,
    output logic          write,
    output logic          read,
    output logic [AW-1:0] address,
    output logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] mem_data_out
);

    if (READ_LATENCY < 1 || READ_LATENCY > (1 << CNT_W) - 1 || MEM_DEPTH < 1) begin : g_param_check
        $error("mem_lsu: READ_LATENCY must be 1..15 and MEM_DEPTH must be positive");
    end

    localparam logic [CNT_W-1:0] LAT_INIT = lat_to_count(READ_LATENCY);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req_ready;
    logic             r_rsp_valid;
    rsp_t             r_rsp;
    logic             r_write;
    logic             r_read;
    logic [AW-1:0]    r_address;
    logic [DW-1:0]    r_wdata;

    state_t           w_state;
    logic [CNT_W-1:0] w_cnt;
    logic             w_req_ready;
    logic             w_rsp_valid;
    rsp_t             w_rsp;
    logic             w_write;
    logic             w_read;
    logic [AW-1:0]    w_address;
    logic [DW-1:0]    w_wdata;

`ifdef MEM_LSU_BOUNDS_CHECK_EN
    logic w_fault;
    assign w_fault = 32'(bus.req_addr) >= 32'(MEM_DEPTH);
`endif

    always_comb begin
        // NOTE: each next-value takes its register's value first, so no branch can infer a latch.
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_req_ready = r_req_ready;
        w_rsp_valid = r_rsp_valid;
        w_rsp       = r_rsp;
        w_write     = r_write;
        w_read      = r_read;
        w_address   = r_address;
        w_wdata     = r_wdata;

        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_req_ready = 1'b0;
                    w_address   = bus.req_addr;
                    w_wdata     = bus.req_wdata;
                    w_rsp       = '0;
`ifdef MEM_LSU_BOUNDS_CHECK_EN
                    if (w_fault) begin
                        w_rsp.error = 1'b1;
                        w_rsp_valid = 1'b1;
                        w_state     = RESP;
                    end else
`endif
                    begin
                        w_write = bus.req_write;
                        w_read  = ~bus.req_write;
                        w_cnt   = LAT_INIT;
                        w_state = ISSUE;
                    end
                end
            end

            ISSUE, WAIT: begin
                if (r_write) begin
                    w_write     = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_state     = RESP;
                end else if (r_cnt == '0) begin
                    // Last read cycle: the memory output is valid at this edge.
                    w_read      = 1'b0;
                    w_rsp.rdata = mem_data_out;
                    w_rsp_valid = 1'b1;
                    w_state     = RESP;
                end else begin
                    w_cnt   = r_cnt - 1'b1;
                    w_state = WAIT;
                end
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_req_ready = 1'b1;
                    w_state     = IDLE;
                end
            end

            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample the same pre-edge values.
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
            r_write     <= 1'b0;
            r_read      <= 1'b0;
            r_address   <= '0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_req_ready <= w_req_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp       <= w_rsp;
            r_write     <= w_write;
            r_read      <= w_read;
            r_address   <= w_address;
            r_wdata     <= w_wdata;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp.rdata;
`ifdef MEM_LSU_BOUNDS_CHECK_EN
    assign bus.rsp_error = r_rsp.error;
`else
    assign bus.rsp_error = 1'b0;
`endif

    assign write       = r_write;
    assign read        = r_read;
    assign address     = r_address;
    assign mem_data_in = r_wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// Testbench for mem_lsu: two instances (READ_LATENCY 1 and 3) against a word-level reference model.
`ifndef A_BITS
`define A_BITS 8
`endif
`ifndef D_BITS
`define D_BITS 16
`endif
`ifndef MEMSIZE
`define MEMSIZE 64
`endif

module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int DEPTH = `MEMSIZE;
    localparam int WORDS = 1 << AW;
`ifdef MEM_LSU_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    always #5 clk = ~clk;

    logic          t_req_valid [2];
    logic          t_req_write [2];
    logic [AW-1:0] t_req_addr  [2];
    logic [DW-1:0] t_req_wdata [2];
    logic          t_rsp_ready [2];
    logic          o_req_ready [2];
    logic          o_rsp_valid [2];
    logic [DW-1:0] o_rsp_rdata [2];
    logic          o_rsp_error [2];
    logic          m_write     [2];
    logic          m_read      [2];
    logic [AW-1:0] m_address   [2];
    logic [DW-1:0] m_wdata     [2];
    logic [DW-1:0] m_rdata     [2];

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_mem [2][WORDS];

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'(i * 40503 + 7);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;

        mem_lsu_if bus ();

        assign bus.req_valid  = t_req_valid[g];
        assign bus.req_write  = t_req_write[g];
        assign bus.req_addr   = t_req_addr[g];
        assign bus.req_wdata  = t_req_wdata[g];
        assign bus.rsp_ready  = t_rsp_ready[g];
        assign o_req_ready[g] = bus.req_ready;
        assign o_rsp_valid[g] = bus.rsp_valid;
        assign o_rsp_rdata[g] = bus.rsp_rdata;
        assign o_rsp_error[g] = bus.rsp_error;

        mem_lsu #(.READ_LATENCY(LAT), .MEM_DEPTH(DEPTH)) dut (
            .clk          (clk),
            .rst          (rst),
            .bus          (bus),
            .write        (m_write[g]),
            .read         (m_read[g]),
            .address      (m_address[g]),
            .mem_data_in  (m_wdata[g]),
            .mem_data_out (m_rdata[g])
        );

        // Memory whose output is only correct in the LAT-th consecutive read cycle.
        logic [DW-1:0] mem [WORDS];
        logic [3:0]    run;
        always @(posedge clk) begin
            if (mem_init) begin
                for (int i = 0; i < WORDS; i++) mem[i] <= init_val(i);
            end else if (m_write[g]) begin
                mem[m_address[g]] <= m_wdata[g];
            end
            if (rst || !m_read[g]) run <= '0;
            else                   run <= run + 4'd1;
        end
        assign m_rdata[g] = (m_read[g] && int'(run) == LAT - 1) ? mem[m_address[g]] : ~mem[m_address[g]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One request/response on instance d; caller is 1 time unit after a rising edge.
    // hold = 0: rsp_ready high in advance; hold > 0: rsp_ready held low that many response cycles.
    task automatic do_txn(input int d, input bit wr, input int addr, input logic [DW-1:0] wdata,
                          input int hold, output int waited);
        int            lat       = (d == 0) ? 1 : 3;
        bit            fault     = BOUNDS && (addr >= DEPTH);
        int            exp_rsp   = fault ? 1 : (wr ? 2 : lat + 1);
        int            exp_nwr   = (!fault && wr) ? 1 : 0;
        int            exp_nrd   = (!fault && !wr) ? lat : 0;
        logic [DW-1:0] exp_rdata = (fault || wr) ? '0 : exp_mem[d][addr];
        int            n_wr = 0, n_rd = 0, n_both = 0, n_bad = 0, n_unstable = 0, rsp_at = 0;

        waited = 0;
        t_rsp_ready[d] = (hold == 0);
        while (!o_req_ready[d] && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("req_ready_wait", o_req_ready[d], 1'b1);

        t_req_valid[d] = 1'b1;
        t_req_write[d] = wr;
        t_req_addr[d]  = AW'(addr);
        t_req_wdata[d] = wdata;
        @(posedge clk); #1;
        t_req_valid[d] = 1'b0;
        t_req_write[d] = 1'($urandom_range(0, 1));
        t_req_addr[d]  = AW'($urandom);
        t_req_wdata[d] = DW'($urandom);
        if (wr && !fault) exp_mem[d][addr] = wdata;

        for (int c = 1; c <= 40 && rsp_at == 0; c++) begin
            if (m_write[d]) n_wr++;
            if (m_read[d]) n_rd++;
            if (m_write[d] && m_read[d]) n_both++;
            if ((m_write[d] || m_read[d]) &&
                (m_address[d] !== AW'(addr) || (m_write[d] && m_wdata[d] !== wdata))) n_bad++;
            if (o_rsp_valid[d]) rsp_at = c;
            else begin
                @(posedge clk); #1;
            end
        end

        check("rsp_cycle", rsp_at, exp_rsp);
        check("write_cycles", n_wr, exp_nwr);
        check("read_cycles", n_rd, exp_nrd);
        check("strobe_overlap", n_both, 0);
        check("strobe_addr_data", n_bad, 0);
        check("rsp_rdata", o_rsp_rdata[d], exp_rdata);
        check("rsp_error", o_rsp_error[d], fault);

        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                if (!o_rsp_valid[d] || o_rsp_rdata[d] !== exp_rdata ||
                    o_rsp_error[d] !== fault || o_req_ready[d] !== 1'b0) n_unstable++;
            end
            check("rsp_hold_stable", n_unstable, 0);
            t_rsp_ready[d] = 1'b1;
        end
        @(posedge clk); #1;
        t_rsp_ready[d] = 1'b0;
        check("rsp_one_cycle", o_rsp_valid[d], 1'b0);
        check("req_ready_after", o_req_ready[d], 1'b1);
    endtask

    initial begin
        int waited;
        int n;
        int d;
        bit wr;
        int addr;
        int hold;

        for (int i = 0; i < 2; i++) begin
            t_req_valid[i] = 1'b0;
            t_req_write[i] = 1'b0;
            t_req_addr[i]  = '0;
            t_req_wdata[i] = '0;
            t_rsp_ready[i] = 1'b0;
            for (int j = 0; j < WORDS; j++) exp_mem[i][j] = init_val(j);
        end
        rst      = 1'b1;
        mem_init = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_init = 1'b0;

        for (int i = 0; i < 2; i++) begin
            check("reset_req_ready", o_req_ready[i], 1'b1);
            check("reset_rsp_valid", o_rsp_valid[i], 1'b0);
            check("reset_rsp_rdata", o_rsp_rdata[i], '0);
            check("reset_rsp_error", o_rsp_error[i], 1'b0);
            check("reset_write", m_write[i], 1'b0);
            check("reset_read", m_read[i], 1'b0);
            check("reset_address", m_address[i], '0);
            check("reset_mem_data_in", m_wdata[i], '0);
        end

        // Store 0x5A to 3 then load it back, latency 1.
        do_txn(0, 1'b1, 3, DW'(16'h005A), 0, waited);
        do_txn(0, 1'b0, 3, '0, 0, waited);
        check("load3_value", exp_mem[0][3], DW'(16'h005A));

        // Latency 3 load with a stalled consumer.
        do_txn(1, 1'b0, 7, '0, 5, waited);

        // Back-to-back with rsp_ready always high: accept right after each response.
        for (int i = 0; i < 4; i++) begin
            do_txn(0, i[0] == 1'b0, 10 + i / 2, DW'($urandom), 0, waited);
            check("b2b_accept_wait", waited, 0);
        end

        // Reset while a latency-3 load sits in WAIT.
        t_rsp_ready[1] = 1'b1;
        t_req_valid[1] = 1'b1;
        t_req_write[1] = 1'b0;
        t_req_addr[1]  = AW'(7);
        @(posedge clk); #1;
        t_req_valid[1] = 1'b0;
        @(posedge clk); #1;
        check("abort_read_before", m_read[1], 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_read", m_read[1], 1'b0);
        check("abort_rsp_valid", o_rsp_valid[1], 1'b0);
        check("abort_req_ready", o_req_ready[1], 1'b1);
        rst = 1'b0;
        n = 0;
        repeat (8) begin
            if (o_rsp_valid[1]) n++;
            @(posedge clk); #1;
        end
        check("abort_no_rsp", n, 0);
        t_rsp_ready[1] = 1'b0;

        // Access at MEM_DEPTH: faults only with the bounds check built in.
        do_txn(0, 1'b0, DEPTH, '0, 2, waited);
        do_txn(1, 1'b1, DEPTH, DW'(16'h1234), 0, waited);
        do_txn(1, 1'b0, DEPTH, '0, 0, waited);

        for (int i = 0; i < 40; i++) begin
            d    = int'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, WORDS - 1))
                                               : int'($urandom_range(0, 15));
            hold = int'($urandom_range(0, 3));
            do_txn(d, wr, addr, DW'($urandom), hold, waited);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Initiator-side load/store unit driving the data-memory port (`write`, `read`, `address`, `mem_data_in`, `mem_data_out`) of the Harvard CPU. It accepts one load or store request at a time from the execute stage over a valid/ready handshake and sequences the memory strobes. It returns load data, or a store acknowledge, over a second valid/ready handshake. It sits between the execute stage and the `memory` block.

## Interface
Parameters:
- `READ_LATENCY`, default 1: cycles `read` is held before `mem_data_out` is sampled. Legal range is 1..15.
- `MEM_DEPTH`, default `` `MEMSIZE ``: number of valid word addresses.

Ports (widths `` `A_BITS `` / `` `D_BITS `` come from macros.vh):
- `clk` in 1: the single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: the execute stage presents a request.
- `req_ready` out 1: the LSU can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in `A_BITS`: word address.
- `req_wdata` in `D_BITS`: store data.
- `rsp_valid` out 1: a response is available.
- `rsp_ready` in 1: the consumer takes the response.
- `rsp_rdata` out `D_BITS`: load data; 0 for stores.
- `rsp_error` out 1: address fault (see Configuration).
- `write` out 1: memory write strobe.
- `read` out 1: memory read strobe.
- `address` out `A_BITS`: memory address.
- `mem_data_in` out `D_BITS`: memory write data.
- `mem_data_out` in `D_BITS`: memory read data.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- In IDLE, `req_ready` is 1. When `req_valid` is also 1, the LSU latches `req_write`/`req_addr`/`req_wdata`, drives `address`/`mem_data_in` from them, and moves to ISSUE.
- ISSUE for a store: `write`=1 for exactly one cycle, then move to RESP with `rsp_rdata`=0.
- ISSUE for a load: `read`=1 and the latency counter loads `READ_LATENCY-1`.
  - If the counter is 0, sample `mem_data_out` into `rsp_rdata` and move to RESP.
  - Otherwise move to WAIT.
- WAIT: `read` stays 1 and the counter decrements. When it reaches 0, sample `mem_data_out` and move to RESP.
- RESP: `rsp_valid`=1. `rsp_rdata`/`rsp_error` are held stable until `rsp_ready`=1, then return to IDLE.
- `req_ready`=0 in every state except IDLE. There is no overlap and no pipelining of requests.
- `write` and `read` are never both 1. Both are 0 outside ISSUE/WAIT.
- `address`/`mem_data_in` stay constant from ISSUE entry until the next accept.
- Reset values: state IDLE; `req_ready`=1; `rsp_valid`=0; `rsp_rdata`=0; `rsp_error`=0; `write`=0; `read`=0; `address`=0; `mem_data_in`=0; counter 0.
- Reset in any state returns to IDLE on that edge. Strobes drop, and any pending response is discarded without being presented.
- Request inputs are ignored outside IDLE.

## Timing
Request accepted at edge k:
- Store: `write` is high in cycle k+1. `rsp_valid` rises in cycle k+2.
- Load: `read` is high in cycles k+1..k+`READ_LATENCY`. `mem_data_out` is sampled at the end of cycle k+`READ_LATENCY`. `rsp_valid` rises in cycle k+`READ_LATENCY`+1.
- Response handshake: when `rsp_valid`&`rsp_ready` complete at edge m, `req_ready` is 1 in cycle m+1. The minimum store-to-store spacing is therefore 3 cycles.
- `rsp_ready` held at 1 in advance: the response still lasts exactly one cycle.

## Configuration
- Macro: `MEM_LSU_BOUNDS_CHECK_EN`.
- Defined: a request with `req_addr` >= `MEM_DEPTH` raises no strobe. The FSM goes IDLE→RESP in cycle k+1 with `rsp_error`=1 and `rsp_rdata`=0.
- Undefined: `rsp_error` is constant 0, the address passes through unchecked, and there is no extra logic.

## Structure
- Package `mem_lsu_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the latency-counter width constant (4 bits);
  - the response struct type (`rdata`, `error`).
- Data widths remain the `` `A_BITS `` / `` `D_BITS `` macros.
- No sub-module: the FSM and counter live in one module.

## Test plan
- Store 0x5A to address 3 → `write`=1 only in cycle k+1 with `address`=3, `mem_data_in`=0x5A. `rsp_valid` in k+2 with `rsp_rdata`=0.
- Load address 3 after that store, `READ_LATENCY`=1 → `read`=1 in k+1 only. `rsp_rdata`=0x5A in k+2.
- `READ_LATENCY`=3, load address 7 → `read` high for exactly 3 cycles. `rsp_valid` in k+4. Holding `rsp_ready`=0 for 5 cycles keeps `rsp_valid`/`rsp_rdata` stable, and `req_ready` stays 0.
- Back-to-back requests with `rsp_ready`=1 always → the second accept occurs exactly in the cycle after the first response. `write` and `read` are never high together.
- `rst` asserted during WAIT → the next cycle has `read`=0, `rsp_valid`=0, `req_ready`=1, and the aborted response never appears.
- With `MEM_LSU_BOUNDS_CHECK_EN`, load `MEM_DEPTH` → no strobe, and `rsp_error`=1 in k+1. Without the macro, the same access strobes `read` and `rsp_error`=0.
